// File: rtl/async_mem_port.sv
// async_mem_port
// Asynchronous responder for a shared flash / PSRAM bus. A single request
// (req + address + to_mem + wren) becomes either a flash read (CE/OE low for
// READ_WAIT cycles, data captured into from_mem) or a PSRAM write (CE/WE low
// for WRITE_WAIT cycles, shared_d driven). Every access ends with a one-cycle
// TURN so the two devices never fight over shared_d. After rst the flash is
// held in reset for RESET_CYCLES cycles and then given the same count to
// recover. Requests arriving while busy are kept in a one-deep, latest-wins
// pending slot and issued back to back.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   address, to_mem, wren, req   request (req may be a single-cycle pulse)
//   from_mem, ready              last read data, responder idle
//   shared_a, shared_d           shared address bus / bidirectional data bus
//   shared_oe_n, shared_we_n     active-low output / write enables
//   flash_ce_n, flash_reset_n    flash select and reset
//   psram_ce_n                   PSRAM select
//   shared_adv_n, psram_cre,
//   shared_clk, psram_lb_n,
//   psram_ub_n                   tied for asynchronous word-wide operation
module async_mem_port #(
  parameter int READ_WAIT    = 8,
  parameter int WRITE_WAIT   = 6,
  parameter int RESET_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [22:0] address,
  input  logic [15:0] to_mem,
  output logic [15:0] from_mem,
  input  logic        req,
  input  logic        wren,
  output logic        ready,
  output logic [22:0] shared_a,
  inout  wire  [15:0] shared_d,
  output logic        shared_oe_n,
  output logic        shared_we_n,
  output logic        flash_ce_n,
  output logic        flash_reset_n,
  output logic        psram_ce_n,
  output logic        shared_adv_n,
  output logic        psram_cre,
  output logic        shared_clk,
  output logic        psram_lb_n,
  output logic        psram_ub_n
);

  typedef enum logic [2:0] {
    RST_HOLD,
    RST_RECOVER,
    IDLE,
    READ,
    WRITE,
    TURN
  } state_t;

  // Counters are loaded with (cycles - 1) and the phase ends when they hit 0.
  localparam logic [4:0] READ_LOAD  = 5'(READ_WAIT - 1);
  localparam logic [4:0] WRITE_LOAD = 5'(WRITE_WAIT - 1);
  localparam logic [4:0] RESET_LOAD = 5'(RESET_CYCLES - 1);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        pend_q, pend_d;
  logic [22:0] req_addr_q, req_addr_d;
  logic [15:0] req_data_q, req_data_d;
  logic        req_wren_q, req_wren_d;
  logic [22:0] op_addr_q, op_addr_d;
  logic [15:0] op_data_q, op_data_d;
  logic [15:0] from_mem_q, from_mem_d;

  logic        cnt_done;
  logic        start_op;
  logic [22:0] nxt_addr;
  logic [15:0] nxt_data;
  logic        nxt_wren;

  // Next-state logic. A request seen on the same edge that an operation could
  // start takes priority over the stored pending one (latest wins).
  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q != 5'd0) ? cnt_q - 5'd1 : cnt_q;
    pend_d     = pend_q;
    req_addr_d = req_addr_q;
    req_data_d = req_data_q;
    req_wren_d = req_wren_q;
    op_addr_d  = op_addr_q;
    op_data_d  = op_data_q;
    from_mem_d = from_mem_q;
    start_op   = 1'b0;
    cnt_done   = (cnt_q == 5'd0);
    nxt_addr   = req ? address : req_addr_q;
    nxt_data   = req ? to_mem  : req_data_q;
    nxt_wren   = req ? wren    : req_wren_q;

    // While busy, a request is parked rather than dropped.
    if (req && state_q != IDLE) begin
      pend_d     = 1'b1;
      req_addr_d = address;
      req_data_d = to_mem;
      req_wren_d = wren;
    end

    case (state_q)
      RST_HOLD: begin
        if (cnt_done) begin
          state_d = RST_RECOVER;
          cnt_d   = RESET_LOAD;
        end
      end
      RST_RECOVER: begin
        if (cnt_done) begin
          if (req || pend_q) start_op = 1'b1;
          else               state_d  = IDLE;
        end
      end
      IDLE: begin
        if (req) start_op = 1'b1;
      end
      READ: begin
        if (cnt_done) begin
          from_mem_d = shared_d;
          state_d    = TURN;
        end
      end
      WRITE: begin
        if (cnt_done) state_d = TURN;
      end
      TURN: begin
        if (req || pend_q) start_op = 1'b1;
        else               state_d  = IDLE;
      end
      default: begin
        state_d = RST_HOLD;
        cnt_d   = RESET_LOAD;
      end
    endcase

    if (start_op) begin
      state_d   = nxt_wren ? WRITE : READ;
      cnt_d     = nxt_wren ? WRITE_LOAD : READ_LOAD;
      op_addr_d = nxt_addr;
      op_data_d = nxt_data;
      pend_d    = 1'b0;
    end
  end

  // State registers; reset restarts the flash reset sequence from any state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RST_HOLD;
      cnt_q      <= RESET_LOAD;
      pend_q     <= 1'b0;
      req_addr_q <= 23'd0;
      req_data_q <= 16'd0;
      req_wren_q <= 1'b0;
      op_addr_q  <= 23'd0;
      op_data_q  <= 16'd0;
      from_mem_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      req_addr_q <= req_addr_d;
      req_data_q <= req_data_d;
      req_wren_q <= req_wren_d;
      op_addr_q  <= op_addr_d;
      op_data_q  <= op_data_d;
      from_mem_q <= from_mem_d;
    end
  end

  // Strobes decode straight from the state register so they are glitch-free
  // and the two chip enables are mutually exclusive by construction.
  assign ready         = (state_q == IDLE);
  assign from_mem      = from_mem_q;
  assign shared_a      = op_addr_q;
  assign flash_ce_n    = (state_q != READ);
  assign shared_oe_n   = (state_q != READ);
  assign psram_ce_n    = (state_q != WRITE);
  assign shared_we_n   = (state_q != WRITE);
  assign flash_reset_n = (state_q != RST_HOLD);
  assign shared_d      = (state_q == WRITE) ? op_data_q : 16'hzzzz;

  assign shared_adv_n  = 1'b0;
  assign shared_clk    = 1'b0;
  assign psram_cre     = 1'b0;
  assign psram_lb_n    = 1'b0;
  assign psram_ub_n    = 1'b0;

endmodule

// File: tb/tb_async_mem_port.sv
// Testbench for async_mem_port. A flash model answers reads with
// address[15:0] ^ 16'hF1F1; when nothing is selected the bench parks the
// data bus at zero so a stray DUT driver shows up as a changed value.
module tb_async_mem_port;

  localparam int RW = 8;
  localparam int WW = 6;
  localparam int RC = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req = 1'b0;
  logic        wren = 1'b0;
  logic [22:0] address = 23'd0;
  logic [15:0] to_mem = 16'd0;
  logic [15:0] from_mem;
  logic        ready;
  logic [22:0] shared_a;
  wire  [15:0] shared_d;
  logic        shared_oe_n, shared_we_n, flash_ce_n, flash_reset_n, psram_ce_n;
  logic        shared_adv_n, psram_cre, shared_clk, psram_lb_n, psram_ub_n;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_n = 0;

  function automatic logic [15:0] flash_data(input logic [22:0] a);
    return a[15:0] ^ 16'hF1F1;
  endfunction

  assign shared_d = (!flash_ce_n && !shared_oe_n) ? flash_data(shared_a) :
                    (psram_ce_n ? 16'h0000 : 16'hzzzz);

  async_mem_port #(.READ_WAIT(RW), .WRITE_WAIT(WW), .RESET_CYCLES(RC)) dut (
    .clk(clk), .rst(rst), .address(address), .to_mem(to_mem),
    .from_mem(from_mem), .req(req), .wren(wren), .ready(ready),
    .shared_a(shared_a), .shared_d(shared_d), .shared_oe_n(shared_oe_n),
    .shared_we_n(shared_we_n), .flash_ce_n(flash_ce_n),
    .flash_reset_n(flash_reset_n), .psram_ce_n(psram_ce_n),
    .shared_adv_n(shared_adv_n), .psram_cre(psram_cre),
    .shared_clk(shared_clk), .psram_lb_n(psram_lb_n), .psram_ub_n(psram_ub_n)
  );

  always #5 clk = ~clk;

  // Timeline reference model: each activity is a start edge plus a length.
  bit          m_in_reset = 1'b1;
  int          m_seq_start = 0;
  bit          m_active = 1'b0;
  int          m_op_start = 0;
  bit          m_op_wr = 1'b0;
  logic [22:0] m_op_addr = 23'd0;
  logic [15:0] m_op_data = 16'd0;
  bit          m_pend = 1'b0;
  bit          m_pend_wr = 1'b0;
  logic [22:0] m_pend_addr = 23'd0;
  logic [15:0] m_pend_data = 16'd0;
  logic [15:0] m_from_mem = 16'd0;
  logic [22:0] m_shared_a = 23'd0;
  logic [65:0] m_exp;

  task automatic m_start(input bit wr, input logic [22:0] a, input logic [15:0] d);
    m_active   = 1'b1;
    m_in_reset = 1'b0;
    m_op_start = edge_n;
    m_op_wr    = wr;
    m_op_addr  = a;
    m_op_data  = d;
    m_shared_a = a;
    m_pend     = 1'b0;
  endtask

  task automatic model_update();
    bit exiting;
    bit op_phase;
    int w;
    if (rst) begin
      m_in_reset  = 1'b1;
      m_seq_start = edge_n;
      m_active    = 1'b0;
      m_pend      = 1'b0;
      m_from_mem  = 16'd0;
      m_shared_a  = 23'd0;
    end else begin
      w = m_op_wr ? WW : RW;
      exiting = (m_in_reset && edge_n == m_seq_start + 2 * RC) ||
                (m_active && edge_n == m_op_start + w + 1);
      if (m_active && !m_op_wr && edge_n == m_op_start + RW)
        m_from_mem = flash_data(m_op_addr);
      if (exiting) begin
        m_in_reset = 1'b0;
        m_active   = 1'b0;
        if (req)         m_start(wren, address, to_mem);
        else if (m_pend) m_start(m_pend_wr, m_pend_addr, m_pend_data);
      end else if (!m_in_reset && !m_active) begin
        if (req) m_start(wren, address, to_mem);
      end else if (req) begin
        m_pend      = 1'b1;
        m_pend_wr   = wren;
        m_pend_addr = address;
        m_pend_data = to_mem;
      end
    end
    w = m_op_wr ? WW : RW;
    op_phase = m_active && (edge_n < m_op_start + w);
    m_exp = {!m_in_reset && !m_active,
             !(m_in_reset && edge_n < m_seq_start + RC),
             !(op_phase && !m_op_wr), !(op_phase && !m_op_wr),
             !(op_phase && m_op_wr),  !(op_phase && m_op_wr),
             5'b00000, m_from_mem, m_shared_a,
             op_phase ? (m_op_wr ? m_op_data : flash_data(m_op_addr)) : 16'h0000};
  endtask

  task automatic tick();
    @(posedge clk);
    edge_n++;
    model_update();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick(); tick();
    n_cmp++;
    if (ready !== 1'b0 || from_mem !== 16'd0) begin
      n_bad++;
      $display("[TB] FAIL reset_ready_data: ready=%b from_mem=%h, want 0/0000", ready, from_mem);
    end
    n_cmp++;
    if ({flash_ce_n, psram_ce_n, shared_oe_n, shared_we_n, flash_reset_n} !== 5'b11110) begin
      n_bad++;
      $display("[TB] FAIL reset_strobes: got %b, want 11110",
               {flash_ce_n, psram_ce_n, shared_oe_n, shared_we_n, flash_reset_n});
    end
    n_cmp++;
    if (shared_a !== 23'd0 || shared_d !== 16'h0000) begin
      n_bad++;
      $display("[TB] FAIL reset_bus: a=%h d=%h, want 000000/0000", shared_a, shared_d);
    end
    n_cmp++;
    if ({shared_adv_n, shared_clk, psram_cre, psram_lb_n, psram_ub_n} !== 5'b00000) begin
      n_bad++;
      $display("[TB] FAIL constants: got %b, want 00000",
               {shared_adv_n, shared_clk, psram_cre, psram_lb_n, psram_ub_n});
    end
  endtask

  task automatic test_reset_pending();
    int low = 0;
    int high = 0;
    bit started = 1'b0;
    rst = 1'b0; req = 1'b1; wren = 1'b0; address = 23'h000010;
    for (int i = 0; i < 100; i++) begin
      if (!flash_ce_n) begin started = 1'b1; break; end
      if (!flash_reset_n) low++; else high++;
      tick();
      req = 1'b0;
    end
    n_cmp++;
    if (!started || low != RC || high != RC) begin
      n_bad++;
      $display("[TB] FAIL reset_sequence: started=%0d low=%0d high=%0d, want 1/%0d/%0d",
               started, low, high, RC, RC);
    end
    n_cmp++;
    if (shared_a !== 23'h000010 || shared_oe_n !== 1'b0) begin
      n_bad++;
      $display("[TB] FAIL pending_read_addr: a=%h oe_n=%b, want 000010/0", shared_a, shared_oe_n);
    end
    for (int i = 0; i < 40 && ready !== 1'b1; i++) tick();
    n_cmp++;
    if (ready !== 1'b1 || from_mem !== 16'hF1E1) begin
      n_bad++;
      $display("[TB] FAIL pending_read_done: ready=%b data=%h, want 1/f1e1", ready, from_mem);
    end
  endtask

  task automatic test_read();
    n_cmp++;
    if (ready !== 1'b1) begin
      n_bad++;
      $display("[TB] FAIL read_idle: ready=%b, want 1", ready);
    end
    req = 1'b1; wren = 1'b0; address = 23'h00ABCD;
    tick();
    req = 1'b0;
    for (int i = 0; i < RW; i++) begin
      n_cmp++;
      if ({ready, flash_ce_n, shared_oe_n, psram_ce_n, shared_d} !== {4'b0001, 16'h5A3C}) begin
        n_bad++;
        $display("[TB] FAIL read_cycle%0d: rdy/ce/oe/pce/d=%b%b%b%b %h, want 0001 5a3c",
                 i, ready, flash_ce_n, shared_oe_n, psram_ce_n, shared_d);
      end
      tick();
    end
    n_cmp++;
    if ({ready, flash_ce_n, shared_oe_n} !== 3'b011 || from_mem !== 16'h5A3C) begin
      n_bad++;
      $display("[TB] FAIL read_turn: rdy/ce/oe=%b%b%b data=%h, want 011/5a3c",
               ready, flash_ce_n, shared_oe_n, from_mem);
    end
    tick();
    n_cmp++;
    if (ready !== 1'b1 || from_mem !== 16'h5A3C) begin
      n_bad++;
      $display("[TB] FAIL read_latency: ready=%b data=%h, want 1/5a3c", ready, from_mem);
    end
  endtask

  task automatic test_write();
    req = 1'b1; wren = 1'b1; address = 23'h000100; to_mem = 16'hBEEF;
    tick();
    req = 1'b0; wren = 1'b0;
    for (int i = 0; i < WW; i++) begin
      n_cmp++;
      if ({ready, psram_ce_n, shared_we_n, flash_ce_n, shared_oe_n, shared_d, shared_a} !==
          {5'b00011, 16'hBEEF, 23'h000100}) begin
        n_bad++;
        $display("[TB] FAIL write_cycle%0d: rdy/pce/we/fce/oe=%b%b%b%b%b d=%h a=%h, want 00011 beef 000100",
                 i, ready, psram_ce_n, shared_we_n, flash_ce_n, shared_oe_n, shared_d, shared_a);
      end
      tick();
    end
    n_cmp++;
    if ({ready, psram_ce_n, shared_we_n, flash_ce_n} !== 4'b0111 || shared_d !== 16'h0000) begin
      n_bad++;
      $display("[TB] FAIL write_turn: rdy/pce/we/fce=%b%b%b%b d=%h, want 0111/0000",
               ready, psram_ce_n, shared_we_n, flash_ce_n, shared_d);
    end
    tick();
    n_cmp++;
    if (ready !== 1'b1 || from_mem !== 16'h5A3C) begin
      n_bad++;
      $display("[TB] FAIL write_done: ready=%b data=%h, want 1/5a3c", ready, from_mem);
    end
  endtask

  task automatic test_back_to_back();
    int busy = 0;
    int starts = 0;
    logic [22:0] start_addr = 23'd0;
    logic prev_ce = 1'b0;
    req = 1'b1; wren = 1'b0; address = 23'h000040;
    tick();
    req = 1'b0;
    tick(); tick();
    req = 1'b1; address = 23'h000020;
    tick();
    address = 23'h000030;
    tick();
    req = 1'b0;
    for (int i = 0; i < 40 && ready !== 1'b1; i++) begin
      if (prev_ce && !flash_ce_n) begin starts++; start_addr = shared_a; end
      prev_ce = flash_ce_n;
      busy++;
      tick();
    end
    n_cmp++;
    if (starts != 1 || start_addr !== 23'h000030) begin
      n_bad++;
      $display("[TB] FAIL b2b_served: starts=%0d addr=%h, want 1/000030", starts, start_addr);
    end
    n_cmp++;
    if (busy != 2 * (RW + 1) - 4 || ready !== 1'b1 || from_mem !== 16'hF1C1) begin
      n_bad++;
      $display("[TB] FAIL b2b_done: busy=%0d ready=%b data=%h, want %0d/1/f1c1",
               busy, ready, from_mem, 2 * (RW + 1) - 4);
    end
  endtask

  task automatic test_reset_mid();
    int wait_n = 0;
    req = 1'b1; wren = 1'b0; address = 23'h000055;
    tick();
    req = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_cmp++;
    if ({ready, flash_ce_n, psram_ce_n, shared_oe_n, shared_we_n, flash_reset_n,
         from_mem, shared_a, shared_d} !== {6'b011110, 16'h0, 23'h0, 16'h0}) begin
      n_bad++;
      $display("[TB] FAIL reset_mid: rdy/fce/pce/oe/we/frst=%b%b%b%b%b%b data=%h a=%h d=%h, want 011110 0 0 0",
               ready, flash_ce_n, psram_ce_n, shared_oe_n, shared_we_n, flash_reset_n,
               from_mem, shared_a, shared_d);
    end
    for (int i = 0; i < 100 && ready !== 1'b1; i++) begin
      wait_n++;
      tick();
    end
    n_cmp++;
    if (wait_n != 2 * RC || from_mem !== 16'h0000) begin
      n_bad++;
      $display("[TB] FAIL reset_restart: cycles=%0d data=%h, want %0d/0000", wait_n, from_mem, 2 * RC);
    end
  endtask

  task automatic test_random();
    logic [65:0] obs;
    for (int i = 0; i < 1500; i++) begin
      rst     = ($urandom_range(0, 299) == 0);
      req     = ($urandom_range(0, 5) == 0);
      wren    = 1'($urandom);
      address = 23'($urandom);
      to_mem  = 16'($urandom);
      tick();
      obs = {ready, flash_reset_n, flash_ce_n, shared_oe_n, psram_ce_n, shared_we_n,
             shared_adv_n, shared_clk, psram_cre, psram_lb_n, psram_ub_n,
             from_mem, shared_a, shared_d};
      n_cmp++;
      if (obs !== m_exp) begin
        n_bad++;
        $display("[TB] FAIL random_cycle%0d: got %h, want %h", i, obs, m_exp);
      end
    end
    rst = 1'b0; req = 1'b0;
  endtask

  initial begin
    test_reset();
    test_reset_pending();
    test_read();
    test_write();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1, "[TB] timeout");
  end

endmodule
